// File: rtl/regfile_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : regfile_cmd_initiator
// Purpose  : Initiator side of the 4-bit register-file bus. Accepts one
//            register request at a time from an upstream command source,
//            issues a single bus transaction, waits for the responder ack
//            (or times out) and returns one response pulse.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_addr/req_data/req_read  - request side
//            bus_valid/bus_address/bus_data                  - bus strobe out
//            bus_ack/bus_rdata/bus_rdata_valid               - bus return
//            rsp_valid/rsp_rdata/rsp_error                   - response side
//            busy                                            - not idle
// Options  : define RETRY_EN to re-issue timed-out transactions up to
//            MAX_RETRY extra times before reporting an error.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_cmd_initiator #(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_data,
  input  logic       req_read,
  output logic       bus_valid,
  output logic [3:0] bus_address,
  output logic [3:0] bus_data,
  input  logic       bus_ack,
  input  logic [3:0] bus_rdata,
  input  logic       bus_rdata_valid,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata,
  output logic       rsp_error,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_BCAST = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_RETRY = 3'd5;

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [3:0] c_READ_CODE = 4'hF;

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              read_q, read_d;
  logic [3:0]        bus_address_q, bus_address_d;
  logic [3:0]        bus_data_q, bus_data_d;
  logic              bus_valid_q, bus_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [3:0]        rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  // Result computed on the transition into RESP.
  logic [3:0]        res_rdata;
  logic              res_error;
  logic              accept;

`ifdef RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  assign accept = req_valid && req_ready_q;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      read_q        <= 1'b0;
      bus_address_q <= 4'h0;
      bus_data_q    <= 4'h0;
      bus_valid_q   <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 4'h0;
      rsp_error_q   <= 1'b0;
`ifdef RETRY_EN
      retry_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      read_q        <= read_d;
      bus_address_q <= bus_address_d;
      bus_data_q    <= bus_data_d;
      bus_valid_q   <= bus_valid_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
`ifdef RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    res_rdata = 4'h0;
    res_error = 1'b0;
`ifdef RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef RETRY_EN
          retry_d = '0;
`endif
          if (!req_read && (req_data == c_READ_CODE)) begin
            // Write data would be indistinguishable from a read on the bus.
            state_d   = S_RESP;
            res_error = 1'b1;
          end else if (req_addr == 4'h0) begin
            state_d = S_BCAST;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (bus_ack) begin
          state_d = S_RESP;
          if (read_q) begin
            if (bus_rdata_valid) res_rdata = bus_rdata;
            else                 res_error = 1'b1;
          end
        end else if (wait_q == c_WAIT_LAST) begin
`ifdef RETRY_EN
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_d = S_RETRY;
            retry_d = retry_q + 1'b1;
          end else begin
            state_d   = S_RESP;
            res_error = 1'b1;
          end
`else
          state_d   = S_RESP;
          res_error = 1'b1;
`endif
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_BCAST: state_d = S_RESP;
      S_RESP:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      S_RETRY: state_d = S_ISSUE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    bus_valid_d   = (state_d == S_ISSUE) || (state_d == S_BCAST);
    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    rsp_valid_d   = (state_d == S_RESP);
    rsp_rdata_d   = (state_d == S_RESP) ? res_rdata : 4'h0;
    rsp_error_d   = (state_d == S_RESP) ? res_error : 1'b0;
    read_d        = read_q;
    bus_address_d = bus_address_q;
    bus_data_d    = bus_data_q;
    if (accept) begin
      read_d        = req_read;
      bus_address_d = req_addr;
      bus_data_d    = req_read ? c_READ_CODE : req_data;
    end
  end

  assign req_ready   = req_ready_q;
  assign bus_valid   = bus_valid_q;
  assign bus_address = bus_address_q;
  assign bus_data    = bus_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
